// File: rtl/nf_branch_pred_unit_if.sv
// Fetch/execute port bundle for nf_branch_pred_unit: the pipeline side is the
// master and the predictor is the slave.
interface nf_branch_pred_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] f_pc;
    logic            f_pred_taken;
    logic            ex_valid;
    logic            ex_branch;
    logic [2:0]      ex_br_type;
    logic [XLEN-1:0] ex_pc;
    logic            ex_pred_taken;
    logic [XLEN-1:0] d0;
    logic [XLEN-1:0] d1;
    logic            pc_b_en;
    logic            br_taken_r;
    logic            mispredict;
    logic            stat_clr;
    logic [31:0]     stat_br_cnt;
    logic [31:0]     stat_mp_cnt;

    modport master (
        output f_pc, ex_valid, ex_branch, ex_br_type, ex_pc, ex_pred_taken,
               d0, d1, stat_clr,
        input  f_pred_taken, pc_b_en, br_taken_r, mispredict,
               stat_br_cnt, stat_mp_cnt
    );

    modport slave (
        input  f_pc, ex_valid, ex_branch, ex_br_type, ex_pc, ex_pred_taken,
               d0, d1, stat_clr,
        output f_pred_taken, pc_b_en, br_taken_r, mispredict,
               stat_br_cnt, stat_mp_cnt
    );
endinterface

// File: rtl/nf_branch_pred_unit.sv
// RV32I conditional-branch resolver with a bimodal 2-bit BHT and registered flush.
// Optional statistics counters are built when NF_BRANCH_STAT_EN is defined.
module nf_branch_pred_unit #(
    parameter int XLEN       = 32,
    parameter int BHT_DEPTH  = 16,
    parameter int PC_IDX_LSB = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    nf_branch_pred_unit_if.slave bp
);
    localparam int IW = $clog2(BHT_DEPTH);

    logic [XLEN-1:0]           op_a, op_b;
    logic                      eq, lt_s, lt_u;
    logic                      cond, legal, resolve, bht_we, mp_src;
    logic [IW-1:0]             idx_f, idx_e;
    logic [BHT_DEPTH-1:0][1:0] bht;
    logic [1:0]                ctr_cur, ctr_next;

    assign op_a = bp.d0;
    assign op_b = bp.d1;
    assign eq   = (op_a == op_b);
    assign lt_s = ($signed(op_a) < $signed(op_b));
    assign lt_u = (op_a < op_b);

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (bp.ex_br_type)
            3'b000:  cond = eq;
            3'b001:  cond = ~eq;
            3'b100:  cond = lt_s;
            3'b101:  cond = ~lt_s;
            3'b110:  cond = lt_u;
            3'b111:  cond = ~lt_u;
            default: legal = 1'b0;
        endcase
    end

    assign resolve    = bp.ex_valid & bp.ex_branch;
    assign bp.pc_b_en = resolve & cond;
    assign bht_we     = resolve & legal;
    assign mp_src     = resolve & (bp.pc_b_en != bp.ex_pred_taken);

    assign idx_f = bp.f_pc[PC_IDX_LSB +: IW];
    assign idx_e = bp.ex_pc[PC_IDX_LSB +: IW];

    // Counter state register; the write lands on the edge, so a same-cycle
    // fetch read of the same index still sees the old value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else if (bht_we) begin
            bht[idx_e] <= ctr_next;
        end
    end

    // Next-state: saturating step toward the resolved direction
    always_comb begin
        ctr_cur  = bht[idx_e];
        ctr_next = ctr_cur;
        if (bp.pc_b_en) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
        end
    end

    // Output: MSB of the counter is the predicted direction
    always_comb begin
        bp.f_pred_taken = bht[idx_f][1];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bp.mispredict <= 1'b0;
            bp.br_taken_r <= 1'b0;
        end else begin
            bp.mispredict <= mp_src;
            if (resolve) bp.br_taken_r <= bp.pc_b_en;
        end
    end

`ifdef NF_BRANCH_STAT_EN
    logic [31:0] br_cnt, mp_cnt;

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else if (bp.stat_clr) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else begin
            if (resolve && br_cnt != 32'hFFFF_FFFF) br_cnt <= br_cnt + 32'd1;
            if (mp_src  && mp_cnt != 32'hFFFF_FFFF) mp_cnt <= mp_cnt + 32'd1;
        end
    end

    assign bp.stat_br_cnt = br_cnt;
    assign bp.stat_mp_cnt = mp_cnt;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = bp.stat_clr;
    assign bp.stat_br_cnt  = '0;
    assign bp.stat_mp_cnt  = '0;
`endif

    // Only the index bits of the PCs matter here
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.f_pc, bp.ex_pc};

endmodule

// File: tb/tb_nf_branch_pred_unit.sv
// Directed bench for nf_branch_pred_unit: condition decode, BHT saturation,
// read/write hazard, illegal types, async reset and optional statistics.
module tb_nf_branch_pred_unit;
    logic clk = 1'b0;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef NF_BRANCH_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    nf_branch_pred_unit_if #(.XLEN(32)) bp ();

    nf_branch_pred_unit #(.XLEN(32), .BHT_DEPTH(16), .PC_IDX_LSB(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bp     (bp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic br, input logic [2:0] t,
                       input logic [31:0] pc, input logic pr,
                       input logic [31:0] a, input logic [31:0] b);
        bp.ex_valid      = v;
        bp.ex_branch     = br;
        bp.ex_br_type    = t;
        bp.ex_pc         = pc;
        bp.ex_pred_taken = pr;
        bp.d0            = a;
        bp.d1            = b;
    endtask

    task automatic idle();
        bp.ex_valid  = 1'b0;
        bp.ex_branch = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        idle();
        bp.stat_clr = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b1;
        bp.f_pc = '0;
        bp.stat_clr = 1'b0;
        drv(0, 0, 3'b000, 32'h0, 0, 32'h0, 32'h0);

        // Reset state and first resolve
        do_reset();
        bp.f_pc = 32'h40;
        #1;
        chk("rst_pred", bp.f_pred_taken, 0);
        chk("rst_mp", bp.mispredict, 0);
        chk("rst_brt", bp.br_taken_r, 0);
        chk("rst_sbr", bp.stat_br_cnt, 0);
        chk("rst_smp", bp.stat_mp_cnt, 0);
        drv(1, 1, 3'b000, 32'h40, 0, 32'd5, 32'd5);
        #1;
        chk("beq_pcb", bp.pc_b_en, 1);
        tick(); idle();
        @(negedge clk);
        chk("beq_mp", bp.mispredict, 1);
        chk("beq_brt", bp.br_taken_r, 1);
        chk("beq_bht", bp.f_pred_taken, 1);
        tick();
        @(negedge clk);
        chk("mp_end", bp.mispredict, 0);
        chk("brt_hold", bp.br_taken_r, 1);

        // Signed vs unsigned compare
        drv(1, 1, 3'b100, 32'h100, 0, 32'hFFFF_FFFF, 32'd1); #1; chk("blt", bp.pc_b_en, 1);
        drv(1, 1, 3'b110, 32'h100, 0, 32'hFFFF_FFFF, 32'd1); #1; chk("bltu", bp.pc_b_en, 0);
        drv(1, 1, 3'b101, 32'h100, 0, 32'hFFFF_FFFF, 32'd1); #1; chk("bge", bp.pc_b_en, 0);
        drv(1, 1, 3'b111, 32'h100, 0, 32'hFFFF_FFFF, 32'd1); #1; chk("bgeu", bp.pc_b_en, 1);
        drv(1, 1, 3'b001, 32'h100, 0, 32'hFFFF_FFFF, 32'd1); #1; chk("bne", bp.pc_b_en, 1);
        drv(1, 1, 3'b000, 32'h100, 0, 32'hFFFF_FFFF, 32'd1); #1; chk("beq_ne", bp.pc_b_en, 0);
        drv(0, 1, 3'b000, 32'h100, 0, 32'd5, 32'd5);         #1; chk("novalid", bp.pc_b_en, 0);
        drv(1, 0, 3'b000, 32'h100, 0, 32'd5, 32'd5);         #1; chk("nobranch", bp.pc_b_en, 0);

        // Saturation and back-to-back pulses at pc 0x40 (index 0)
        do_reset();
        bp.f_pc = 32'h40;
        drv(1, 1, 3'b000, 32'h40, 0, 32'd5, 32'd5); tick();
        drv(1, 1, 3'b000, 32'h40, 0, 32'd5, 32'd5); @(negedge clk); chk("b2b_mp0", bp.mispredict, 1); tick();
        drv(1, 1, 3'b000, 32'h40, 1, 32'd5, 32'd5); @(negedge clk); chk("b2b_mp1", bp.mispredict, 1); tick();
        drv(1, 1, 3'b000, 32'h40, 1, 32'd5, 32'd5); @(negedge clk); chk("ok_mp2", bp.mispredict, 0); tick();
        idle(); @(negedge clk);
        chk("ok_mp3", bp.mispredict, 0);
        chk("sat_st", bp.f_pred_taken, 1);
        drv(1, 1, 3'b001, 32'h40, 1, 32'd5, 32'd5); tick(); idle(); @(negedge clk);
        chk("nt_mp", bp.mispredict, 1);
        chk("nt_brt", bp.br_taken_r, 0);
        chk("st_to_wt", bp.f_pred_taken, 1);
        drv(1, 1, 3'b001, 32'h40, 0, 32'd5, 32'd5); tick(); idle(); @(negedge clk);
        chk("wt_to_wnt", bp.f_pred_taken, 0);
        drv(1, 1, 3'b001, 32'h40, 0, 32'd5, 32'd5); tick(); tick(); idle(); @(negedge clk);
        chk("snt_pred", bp.f_pred_taken, 0);
        drv(1, 1, 3'b000, 32'h40, 0, 32'd5, 32'd5); tick(); idle(); @(negedge clk);
        chk("snt_sat", bp.f_pred_taken, 0);

        // Same-cycle read/write of one index
        do_reset();
        bp.f_pc = 32'h80;
        drv(1, 1, 3'b000, 32'h80, 0, 32'd7, 32'd7);
        #1;
        chk("haz_old", bp.f_pred_taken, 0);
        tick(); idle(); @(negedge clk);
        chk("haz_new", bp.f_pred_taken, 1);

        // Illegal type, invalid slot, and statistics
        do_reset();
        bp.f_pc = 32'h40;
        drv(0, 1, 3'b010, 32'h40, 1, 32'd5, 32'd5); tick(); idle(); @(negedge clk);
        chk("inv_mp", bp.mispredict, 0);
        drv(1, 1, 3'b010, 32'h40, 1, 32'd5, 32'd5); #1;
        chk("ill_pcb", bp.pc_b_en, 0);
        tick(); idle(); @(negedge clk);
        chk("ill_mp", bp.mispredict, 1);
        chk("ill_brt", bp.br_taken_r, 0);
        drv(1, 1, 3'b000, 32'h40, 1, 32'd5, 32'd5); tick(); idle(); @(negedge clk);
        chk("ill_noupd", bp.f_pred_taken, 1);
        chk("st_br", bp.stat_br_cnt, STAT ? 32'd2 : 32'd0);
        chk("st_mp", bp.stat_mp_cnt, STAT ? 32'd1 : 32'd0);
        drv(1, 1, 3'b000, 32'h40, 0, 32'd5, 32'd5);
        bp.stat_clr = 1'b1;
        tick(); idle(); bp.stat_clr = 1'b0; @(negedge clk);
        chk("clr_mp", bp.mispredict, 1);
        chk("clr_br", bp.stat_br_cnt, 0);
        chk("clr_mpc", bp.stat_mp_cnt, 0);

        // Async reset between resolve and pulse
        do_reset();
        bp.f_pc = 32'h40;
        drv(1, 1, 3'b000, 32'h40, 1, 32'd5, 32'd5); tick();
        drv(1, 1, 3'b000, 32'h40, 0, 32'd5, 32'd5);
        @(negedge clk);
        chk("pre_rst_bht", bp.f_pred_taken, 1);
        resetn = 1'b0;
        tick(); idle();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("arst_mp", bp.mispredict, 0);
        chk("arst_brt", bp.br_taken_r, 0);
        chk("arst_bht", bp.f_pred_taken, 0);
        chk("arst_sbr", bp.stat_br_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
